seg_arbiter: RTL and testbench

- Shares the single 4-digit seven-segment display path (dis0..dis3 into s_segment) between three requesters.
  - Live: score/clock from the basket FSM; the default owner.
  - Event: transient banner, e.g. goal flash.
  - Alert: highest priority, e.g. time-up or reset warning.
- Grants by fixed priority and holds a granted transient for a fixed number of ticks.
- Lives in top, between the fsm outputs and s_segment.

---
 rtl/seg_arb_pkg.sv | 14 +
 rtl/seg_arbiter_hold_timer.sv | 39 +++
 rtl/seg_arbiter.sv | 171 +++++++++++++++++
 tb/tb_seg_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_arb_pkg.sv
// Shared definitions for the seven-segment display arbiter: state/owner codes,
// the default blank digit code and the hold counter width.
package seg_arb_pkg;

  typedef enum logic [1:0] {
    ST_LIVE  = 2'd0,
    ST_EVENT = 2'd1,
    ST_ALERT = 2'd2
  } seg_state_t;

  localparam logic [3:0] BLANK_CODE_DEF = 4'hF;
  localparam int         HOLD_CNT_W     = 4;

endpackage

// File: rtl/seg_arbiter_hold_timer.sv
// Counts tick strobes while a transient owns the display; done pulses on the
// tick that completes HOLD_TICKS ticks. A restart wins over a same-cycle tick.
module hold_timer
  import seg_arb_pkg::*;
#(
  parameter int HOLD_TICKS = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic tick,
  input  logic en,
  output logic done
);

  localparam logic [HOLD_CNT_W-1:0] LAST = HOLD_CNT_W'(HOLD_TICKS - 1);

  logic [HOLD_CNT_W-1:0] cnt_reg, cnt_next;

  always_comb begin
    done     = en && tick && !restart && (cnt_reg == LAST);
    cnt_next = cnt_reg;
    if (restart) begin
      cnt_next = '0;
    end else if (en && tick) begin
      // Expiry clears the count, so it never reaches the wrap point.
      cnt_next = done ? '0 : cnt_reg + HOLD_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/seg_arbiter.sv
// Fixed-priority owner of the 4-digit display path (alert > event > live).
// Optional alert blinking is enabled by defining SEG_ARB_BLINK_EN.
module seg_arbiter
  import seg_arb_pkg::*;
#(
  parameter int         HOLD_TICKS = 3,
  parameter logic [3:0] BLANK_CODE = BLANK_CODE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic [15:0] live_dig,
  input  logic        ev_req,
  input  logic [15:0] ev_dig,
  input  logic        al_req,
  input  logic [15:0] al_dig,
  output logic [3:0]  dis0,
  output logic [3:0]  dis1,
  output logic [3:0]  dis2,
  output logic [3:0]  dis3,
  output logic [1:0]  owner,
  output logic        ev_ack,
  output logic        ev_drop,
  output logic        al_ack
);

  seg_state_t  state_reg, state_next;
  logic [15:0] payload_reg, payload_next;
  logic [15:0] dis_reg, dis_next;
  logic        ev_ack_reg, ev_ack_next;
  logic        ev_drop_reg, ev_drop_next;
  logic        al_ack_reg, al_ack_next;
  logic        restart, timer_en, done, blank;

  hold_timer #(.HOLD_TICKS(HOLD_TICKS)) u_hold_timer (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick),
    .en      (timer_en),
    .done    (done)
  );

  always_comb begin
    state_next   = state_reg;
    payload_next = payload_reg;
    ev_ack_next  = 1'b0;
    ev_drop_next = 1'b0;
    al_ack_next  = 1'b0;
    restart      = 1'b0;
    timer_en     = 1'b0;
    case (state_reg)
      ST_LIVE: begin
        if (al_req) begin
          state_next   = ST_ALERT;
          payload_next = al_dig;
          al_ack_next  = 1'b1;
          ev_drop_next = ev_req;
          restart      = 1'b1;
        end else if (ev_req) begin
          state_next   = ST_EVENT;
          payload_next = ev_dig;
          ev_ack_next  = 1'b1;
          restart      = 1'b1;
        end
      end
      ST_EVENT: begin
        timer_en = 1'b1;
        if (al_req) begin
          // The aborted event is discarded, never resumed after the alert.
          state_next   = ST_ALERT;
          payload_next = al_dig;
          al_ack_next  = 1'b1;
          ev_drop_next = 1'b1;
          restart      = 1'b1;
        end else if (ev_req) begin
          payload_next = ev_dig;
          ev_ack_next  = 1'b1;
          restart      = 1'b1;
        end else if (done) begin
          state_next = ST_LIVE;
        end
      end
      ST_ALERT: begin
        // A rejected event still consumes the cycle, so its tick is ignored.
        timer_en = !ev_req;
        if (al_req) begin
          payload_next = al_dig;
          al_ack_next  = 1'b1;
          ev_drop_next = ev_req;
          restart      = 1'b1;
        end else if (ev_req) begin
          ev_drop_next = 1'b1;
        end else if (done) begin
          state_next = ST_LIVE;
        end
      end
      default: begin
        state_next = ST_LIVE;
      end
    endcase
  end

`ifdef SEG_ARB_BLINK_EN
  logic phase_reg, phase_next;

  always_comb begin
    phase_next = 1'b0;
    if (state_next == ST_ALERT && !restart) begin
      phase_next = phase_reg ^ (timer_en & tick);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_reg <= 1'b0;
    end else begin
      phase_reg <= phase_next;
    end
  end

  assign blank = phase_next;
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    dis_next = payload_next;
    if (state_next == ST_LIVE) begin
      dis_next = live_dig;
    end else if (blank) begin
      dis_next = {4{BLANK_CODE}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_LIVE;
      payload_reg <= '0;
      dis_reg     <= '0;
      ev_ack_reg  <= 1'b0;
      ev_drop_reg <= 1'b0;
      al_ack_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      payload_reg <= payload_next;
      dis_reg     <= dis_next;
      ev_ack_reg  <= ev_ack_next;
      ev_drop_reg <= ev_drop_next;
      al_ack_reg  <= al_ack_next;
    end
  end

  logic [3:0] dis_arr [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_dig
      assign dis_arr[gi] = dis_reg[gi*4 +: 4];
    end
  endgenerate

  assign dis0    = dis_arr[0];
  assign dis1    = dis_arr[1];
  assign dis2    = dis_arr[2];
  assign dis3    = dis_arr[3];
  assign owner   = state_reg;
  assign ev_ack  = ev_ack_reg;
  assign ev_drop = ev_drop_reg;
  assign al_ack  = al_ack_reg;

endmodule

// File: tb/tb_seg_arbiter.sv
// Directed and randomized checks of seg_arbiter against a countdown-based
// reference model of display ownership.
module tb_seg_arbiter;

  localparam int HOLD = 3;
`ifdef SEG_ARB_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, tick, ev_req, al_req;
  logic [15:0] live_dig, ev_dig, al_dig;
  logic [3:0]  dis0, dis1, dis2, dis3;
  logic [1:0]  owner;
  logic        ev_ack, ev_drop, al_ack;

  int checks = 0;
  int errors = 0;

  // Reference model: owner mode, payload, ticks remaining, blink phase
  int          m_mode;
  int          m_left;
  bit          m_phase;
  logic [15:0] m_pay;
  logic [15:0] e_dis;
  bit          e_ev_ack, e_ev_drop, e_al_ack;

  always #5 clk = ~clk;

  seg_arbiter #(.HOLD_TICKS(HOLD), .BLANK_CODE(4'hF)) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .live_dig (live_dig),
    .ev_req   (ev_req),
    .ev_dig   (ev_dig),
    .al_req   (al_req),
    .al_dig   (al_dig),
    .dis0     (dis0),
    .dis1     (dis1),
    .dis2     (dis2),
    .dis3     (dis3),
    .owner    (owner),
    .ev_ack   (ev_ack),
    .ev_drop  (ev_drop),
    .al_ack   (al_ack)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    e_ev_ack  = 1'b0;
    e_ev_drop = 1'b0;
    e_al_ack  = 1'b0;
    if (rst) begin
      m_mode  = 0;
      m_pay   = '0;
      m_left  = 0;
      m_phase = 1'b0;
      e_dis   = '0;
      return;
    end
    if (al_req) begin
      e_ev_drop = ev_req || (m_mode == 1);
      e_al_ack  = 1'b1;
      m_mode    = 2;
      m_pay     = al_dig;
      m_left    = HOLD;
      m_phase   = 1'b0;
    end else if (ev_req) begin
      if (m_mode == 2) begin
        e_ev_drop = 1'b1;
      end else begin
        e_ev_ack = 1'b1;
        m_mode   = 1;
        m_pay    = ev_dig;
        m_left   = HOLD;
        m_phase  = 1'b0;
      end
    end else if (tick && m_mode != 0) begin
      m_left--;
      if (m_mode == 2) m_phase = !m_phase;
      if (m_left == 0) begin
        m_mode  = 0;
        m_phase = 1'b0;
      end
    end
    e_dis = (m_mode == 0) ? live_dig : ((BLINK && m_phase) ? 16'hFFFF : m_pay);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("owner", 16'(owner), 16'(m_mode));
    chk("dis", {dis3, dis2, dis1, dis0}, e_dis);
    chk("ev_ack", 16'(ev_ack), 16'(e_ev_ack));
    chk("ev_drop", 16'(ev_drop), 16'(e_ev_drop));
    chk("al_ack", 16'(al_ack), 16'(e_al_ack));
    $display("t=%0t rst=%b tick=%b ev=%b al=%b owner=%0d dis=%h ack=%b drop=%b al_ack=%b",
             $time, rst, tick, ev_req, al_req, owner, {dis3, dis2, dis1, dis0},
             ev_ack, ev_drop, al_ack);
  endtask

  task automatic tick_gap();
    tick = 1'b1;
    cycle();
    tick = 1'b0;
    cycle();
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; ev_req = 1'b1; al_req = 1'b0;
    live_dig = 16'h0000; ev_dig = 16'h5555; al_dig = 16'h0000;

    // Reset overrides a pending event request
    cycle();
    cycle();
    chk("rst_owner", 16'(owner), 16'h0);
    chk("rst_dis", {dis3, dis2, dis1, dis0}, 16'h0000);
    chk("rst_ev_ack", 16'(ev_ack), 16'h0);
    rst = 1'b0; ev_req = 1'b0; live_dig = 16'h1203;
    cycle();
    chk("live_track", {dis3, dis2, dis1, dis0}, 16'h1203);

    // Event hold for three ticks
    ev_req = 1'b1; ev_dig = 16'hA00A;
    cycle();
    ev_req = 1'b0;
    chk("ev_ack_pulse", 16'(ev_ack), 16'h1);
    chk("ev_owner", 16'(owner), 16'h1);
    chk("ev_dis", {dis3, dis2, dis1, dis0}, 16'hA00A);
    tick_gap();
    tick_gap();
    chk("ev_hold2", 16'(owner), 16'h1);
    tick_gap();
    chk("ev_expire_owner", 16'(owner), 16'h0);
    chk("ev_expire_dis", {dis3, dis2, dis1, dis0}, 16'h1203);

    // Alert pre-empts an active event and returns to LIVE
    ev_req = 1'b1; ev_dig = 16'hA00A;
    cycle();
    ev_req = 1'b0;
    tick_gap();
    al_req = 1'b1; al_dig = 16'hEEEE;
    cycle();
    al_req = 1'b0;
    chk("pre_al_ack", 16'(al_ack), 16'h1);
    chk("pre_ev_drop", 16'(ev_drop), 16'h1);
    chk("pre_owner", 16'(owner), 16'h2);
    chk("pre_dis", {dis3, dis2, dis1, dis0}, 16'hEEEE);
    tick_gap();
    tick_gap();
    chk("pre_hold", 16'(owner), 16'h2);
    tick_gap();
    chk("pre_back_live", 16'(owner), 16'h0);

    // Event, alert and tick together from LIVE; then event during ALERT
    ev_req = 1'b1; al_req = 1'b1; tick = 1'b1; ev_dig = 16'h5678; al_dig = 16'h1234;
    cycle();
    al_req = 1'b0; tick = 1'b0;
    chk("sim_owner", 16'(owner), 16'h2);
    chk("sim_al_ack", 16'(al_ack), 16'h1);
    chk("sim_ev_drop", 16'(ev_drop), 16'h1);
    cycle();
    ev_req = 1'b0;
    chk("col_ev_drop", 16'(ev_drop), 16'h1);
    chk("col_owner", 16'(owner), 16'h2);
    tick_gap();
    tick_gap();
    chk("sim_hold", 16'(owner), 16'h2);
    tick_gap();
    chk("sim_expire", 16'(owner), 16'h0);

    // Event restart reloads payload and hold time
    ev_req = 1'b1; ev_dig = 16'h0550;
    cycle();
    ev_req = 1'b0;
    tick_gap();
    tick_gap();
    ev_req = 1'b1; ev_dig = 16'h0001;
    cycle();
    ev_req = 1'b0;
    chk("rs_dis", {dis3, dis2, dis1, dis0}, 16'h0001);
    tick_gap();
    tick_gap();
    chk("rs_hold", 16'(owner), 16'h1);
    tick_gap();
    chk("rs_expire", 16'(owner), 16'h0);

    // Alert display across ticks (blanked on odd phase when blinking)
    al_req = 1'b1; al_dig = 16'h9999;
    cycle();
    al_req = 1'b0;
    chk("bl_entry", {dis3, dis2, dis1, dis0}, 16'h9999);
    tick_gap();
    chk("bl_tick1", {dis3, dis2, dis1, dis0}, BLINK ? 16'hFFFF : 16'h9999);
    tick_gap();
    chk("bl_tick2", {dis3, dis2, dis1, dis0}, 16'h9999);
    tick_gap();
    chk("bl_live", {dis3, dis2, dis1, dis0}, 16'h1203);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 199) == 0);
      tick     = ($urandom_range(0, 3) == 0);
      ev_req   = ($urandom_range(0, 7) == 0);
      al_req   = ($urandom_range(0, 15) == 0);
      ev_dig   = 16'($urandom);
      al_dig   = 16'($urandom);
      live_dig = 16'($urandom);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
